regbank_exec: RTL and testbench

Execution sequencer that drives a 4 x 32-bit register file (2 async read ports, 1 clocked write port) from a stream of register-to-register instructions. It sits between the instruction source and the register file. It accepts one instruction per cycle via valid/ready, reads operands, executes in a 2-stage pipeline (RD/EX then WB) with write-back forwarding, and issues the register-file write.

---
 rtl/regbank_pkg.sv | 25 ++
 rtl/regbank_alu.sv | 44 ++++
 rtl/regbank_exec.sv | 166 ++++++++++++++++
 tb/tb_regbank_exec.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg
//   Shared widths, opcode encodings and small decode helpers for the
//   regbank execution sequencer and its ALU.
package regbank_pkg;

    localparam int DW = 32;   // data width
    localparam int RW = 2;    // register index width

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MOV = 3'd5,
        OP_LDI = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    // Only ADD and SUB touch the carry flag; everything else leaves it alone.
    function automatic logic op_sets_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/regbank_alu.sv
// regbank_alu
//   Combinational single-cycle ALU for every opcode except MUL (MUL is
//   iterated in the sequencer and this block returns 0 for it).
//   Ports:
//     op   - opcode
//     a, b - operands (already forwarded)
//     imm  - immediate for LDI
//     res  - 32-bit result, modulo 2^32
//     cout - carry-out for ADD, borrow (a < b unsigned) for SUB, else 0
module regbank_alu
    import regbank_pkg::*;
(
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] res,
    output logic          cout
);

    logic [DW:0] sum;
    logic [DW:0] dif;

    // One extra bit on each side: bit DW is carry for the sum and borrow
    // for the difference.
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        res  = '0;
        cout = 1'b0;
        case (op)
            OP_ADD: begin res = sum[DW-1:0]; cout = sum[DW]; end
            OP_SUB: begin res = dif[DW-1:0]; cout = dif[DW]; end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_MOV: res = a;
            OP_LDI: res = imm;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/regbank_exec.sv
// regbank_exec
//   Two-stage (RD/EX, WB) execution sequencer for a 4 x 32 register file.
//   Accepts one instruction per cycle, reads operands through two async
//   read ports with write-back forwarding, executes, and issues the
//   register-file write from the WB stage. MUL is iterated over 4 cycles,
//   one operand-B byte per cycle.
//   Ports:
//     clk, rst                    - clock, synchronous active-high reset
//     in_valid/in_ready           - instruction handshake
//     in_op/in_sr1/in_sr2/in_dr   - opcode and register indices
//     in_imm                      - immediate for LDI
//     rf_sr1/rf_sr2               - register-file read selects
//     rf_rdData1/rf_rdData2       - register-file read data (combinational)
//     rf_dr/rf_write/rf_wrData    - register-file write port
//     zf, cf                      - zero and carry/borrow flags
module regbank_exec
    import regbank_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [RW-1:0] in_sr1,
    input  logic [RW-1:0] in_sr2,
    input  logic [RW-1:0] in_dr,
    input  logic [DW-1:0] in_imm,
    output logic [RW-1:0] rf_sr1,
    output logic [RW-1:0] rf_sr2,
    input  logic [DW-1:0] rf_rdData1,
    input  logic [DW-1:0] rf_rdData2,
    output logic [RW-1:0] rf_dr,
    output logic          rf_write,
    output logic [DW-1:0] rf_wrData,
    output logic          zf,
    output logic          cf
);

    // RD stage registers
    logic          s1_valid;
    logic [2:0]    s1_op;
    logic [RW-1:0] s1_sr1;
    logic [RW-1:0] s1_sr2;
    logic [RW-1:0] s1_dr;
    logic [DW-1:0] s1_imm;

    // MUL iteration state
    logic [1:0]    mcnt;
    logic [DW-1:0] ma;
    logic [DW-1:0] mb;
    logic [DW-1:0] acc;

    // WB stage
    logic          wb_valid;

    logic          s1_is_mul;
    logic          s1_last;
    logic          accept;
    logic          retire;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] alu_res;
    logic          alu_cout;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic [7:0]    mul_byte;
    logic [DW-1:0] mul_pp;
    logic [DW-1:0] mul_sum;
    logic [DW-1:0] result;

    assign rf_sr1   = s1_sr1;
    assign rf_sr2   = s1_sr2;
    assign rf_write = wb_valid;

    // The bank only commits at the end of the WB cycle, so a read of the
    // register being written this cycle must take the WB data instead.
    assign opa = (wb_valid && (rf_dr == s1_sr1)) ? rf_wrData : rf_rdData1;
    assign opb = (wb_valid && (rf_dr == s1_sr2)) ? rf_wrData : rf_rdData2;

    assign s1_is_mul = (s1_op == OP_MUL);
    assign s1_last   = !s1_is_mul || (mcnt == 2'd3);

    // State-only: never looks at in_valid.
    assign in_ready = !s1_valid || s1_last;
    assign accept   = in_valid && in_ready;
    assign retire   = s1_valid && s1_last;

    regbank_alu u_alu (
        .op   (s1_op),
        .a    (opa),
        .b    (opb),
        .imm  (s1_imm),
        .res  (alu_res),
        .cout (alu_cout)
    );

    // MUL: on the first iteration the forwarded operands are used directly
    // (they are latched into ma/mb at the same edge) and the accumulator is
    // treated as zero; later iterations use the latched copies, because the
    // forwarding source has moved on by then.
    assign mul_a    = (mcnt == 2'd0) ? opa : ma;
    assign mul_b    = (mcnt == 2'd0) ? opb : mb;
    assign mul_byte = mul_b[{mcnt, 3'b000} +: 8];
    assign mul_pp   = (mul_a * {{(DW-8){1'b0}}, mul_byte}) << {mcnt, 3'b000};
    assign mul_sum  = ((mcnt == 2'd0) ? '0 : acc) + mul_pp;

    // Final MUL partial sum is only consumed at mcnt==3, when s1_last holds.
    assign result = s1_is_mul ? mul_sum : alu_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_sr1    <= '0;
            s1_sr2    <= '0;
            s1_dr     <= '0;
            s1_imm    <= '0;
            mcnt      <= '0;
            ma        <= '0;
            mb        <= '0;
            acc       <= '0;
            wb_valid  <= 1'b0;
            rf_dr     <= '0;
            rf_wrData <= '0;
            zf        <= 1'b0;
            cf        <= 1'b0;
        end else begin
            // WB stage
            if (retire) begin
                wb_valid  <= 1'b1;
                rf_dr     <= s1_dr;
                rf_wrData <= result;
                zf        <= (result == '0);
                if (op_sets_carry(s1_op))
                    cf <= alu_cout;
            end else begin
                wb_valid <= 1'b0;
            end

            // RD stage
            if (accept) begin
                s1_valid <= 1'b1;
                s1_op    <= in_op;
                s1_sr1   <= in_sr1;
                s1_sr2   <= in_sr2;
                s1_dr    <= in_dr;
                s1_imm   <= in_imm;
            end else if (retire) begin
                s1_valid <= 1'b0;
            end

            // MUL iteration; retire and advance are mutually exclusive
            if (retire) begin
                mcnt <= '0;
            end else if (s1_valid && s1_is_mul) begin
                mcnt <= mcnt + 2'd1;
                acc  <= mul_sum;
                if (mcnt == 2'd0) begin
                    ma <= opa;
                    mb <= opb;
                end
            end
        end
    end

endmodule

// File: tb/tb_regbank_exec.sv
module tb_regbank_exec;
    import regbank_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [1:0]  in_sr1, in_sr2, in_dr;
    logic [31:0] in_imm;
    logic [1:0]  rf_sr1, rf_sr2, rf_dr;
    logic [31:0] rf_rdData1, rf_rdData2, rf_wrData;
    logic        rf_write, zf, cf;

    always #5 clk = ~clk;

    regbank_exec dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr), .in_imm(in_imm),
        .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
        .rf_rdData1(rf_rdData1), .rf_rdData2(rf_rdData2),
        .rf_dr(rf_dr), .rf_write(rf_write), .rf_wrData(rf_wrData),
        .zf(zf), .cf(cf)
    );

    // 4 x 32 register file: async reads, write commits on the clock edge
    logic [31:0] rf [4];
    always @(posedge clk) if (rf_write) rf[rf_dr] <= rf_wrData;
    assign rf_rdData1 = rf[rf_sr1];
    assign rf_rdData2 = rf[rf_sr2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  dr;
        logic [31:0] d;
        logic        z;
        logic        c;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];

    always @(negedge clk) begin
        if (rf_write) begin
            wr_t o;
            o.cyc = cyc; o.dr = rf_dr; o.d = rf_wrData; o.z = zf; o.c = cf;
            obs_q.push_back(o);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural shadow state, updated in program order
    logic [31:0] mrf [4] = '{default: 32'h0};
    logic        mcf = 1'b0;

    task automatic issue(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] d, input logic [31:0] imm, output int n);
        int w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL issue_ready: in_ready=%0b after %0d cycles, required 1", in_ready, w);
        end
        in_valid = 1'b1; in_op = op; in_sr1 = s1; in_sr2 = s2; in_dr = d; in_imm = imm;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = cyc;
    endtask

    task automatic expect_op(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2,
                             input logic [1:0] d, input logic [31:0] imm, input int n);
        logic [31:0] a, b, r;
        logic [32:0] w;
        wr_t e;
        a = mrf[s1]; b = mrf[s2];
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; mcf = w[32]; end
            3'd1: begin r = a - b; mcf = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a;
            3'd6: r = imm;
            default: r = a * b;
        endcase
        mrf[d] = r;
        e.cyc = n + ((op == 3'd7) ? 4 : 1);
        e.dr = d; e.d = r; e.z = (r == 32'h0); e.c = mcf;
        exp_q.push_back(e);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] d, input logic [31:0] imm);
        int n;
        issue(op, s1, s2, d, imm, n);
        expect_op(op, s1, s2, d, imm, n);
    endtask

    // Waits (bounded) until every expected write has been seen, plus a
    // few cycles to catch stray extra writes and let the bank commit.
    task automatic drain(output bit timed_out);
        int w = 0;
        while (obs_q.size() < exp_q.size() && w < 60) begin @(posedge clk); #1; w++; end
        timed_out = (obs_q.size() < exp_q.size());
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0;
        in_op = '0; in_sr1 = '0; in_sr2 = '0; in_dr = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rf_write !== 1'b0 || in_ready !== 1'b1 || zf !== 1'b0 || cf !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: write=%0b ready=%0b zf=%0b cf=%0b, required 0 1 0 0",
                         i, rf_write, in_ready, zf, cf);
            end
            @(posedge clk); #1;
        end
        obs_q.delete();
    endtask

    task automatic test_ldi_add;
        bit to; wr_t e, o;
        do_op(OP_LDI, 0, 0, 0, 32'd5);
        do_op(OP_LDI, 0, 0, 1, 32'd3);
        do_op(OP_ADD, 0, 1, 2, 32'd0);
        drain(to);
        n_checks++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ldi_add count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ldi_add write: got cyc=%0d dr=%0d d=%h z=%0b c=%0b, required cyc=%0d dr=%0d d=%h z=%0b c=%0b",
                         o.cyc, o.dr, o.d, o.z, o.c, e.cyc, e.dr, e.d, e.z, e.c);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_checks++;
        if (rf[2] !== 32'd8) begin n_fail++; $display("FAIL ldi_add R2: got %h, required 00000008", rf[2]); end
    endtask

    task automatic test_sub;
        bit to; wr_t e, o;
        do_op(OP_SUB, 1, 0, 3, 32'd0);
        do_op(OP_SUB, 0, 0, 0, 32'd0);
        drain(to);
        n_checks++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL sub count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sub write: got cyc=%0d dr=%0d d=%h z=%0b c=%0b, required cyc=%0d dr=%0d d=%h z=%0b c=%0b",
                         o.cyc, o.dr, o.d, o.z, o.c, e.cyc, e.dr, e.d, e.z, e.c);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_checks++;
        if (rf[3] !== 32'hFFFF_FFFE || rf[0] !== 32'h0) begin
            n_fail++; $display("FAIL sub regs: got R3=%h R0=%h, required fffffffe 00000000", rf[3], rf[0]);
        end
    endtask

    task automatic test_carry;
        bit to; wr_t e, o;
        do_op(OP_LDI, 0, 0, 0, 32'hFFFF_FFFF);
        do_op(OP_LDI, 0, 0, 1, 32'd1);
        do_op(OP_ADD, 0, 1, 2, 32'd0);
        drain(to);
        n_checks++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL carry count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL carry write: got cyc=%0d dr=%0d d=%h z=%0b c=%0b, required cyc=%0d dr=%0d d=%h z=%0b c=%0b",
                         o.cyc, o.dr, o.d, o.z, o.c, e.cyc, e.dr, e.d, e.z, e.c);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_checks++;
        if (rf[2] !== 32'h0 || zf !== 1'b1 || cf !== 1'b1) begin
            n_fail++; $display("FAIL carry flags: got R2=%h zf=%0b cf=%0b, required 00000000 1 1", rf[2], zf, cf);
        end
    endtask

    task automatic test_mul;
        bit to; wr_t e, o; int n;
        do_op(OP_LDI, 0, 0, 0, 32'h0001_0003);
        do_op(OP_LDI, 0, 0, 1, 32'd7);
        issue(OP_MUL, 0, 1, 2, 32'd0, n);
        expect_op(OP_MUL, 0, 1, 2, 32'd0, n);
        // now in cycle N+1; in_ready low for three cycles, high in the fourth
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (in_ready !== (k == 3)) begin
                n_fail++; $display("FAIL mul_ready N+%0d: got %0b, required %0b", k + 1, in_ready, (k == 3));
            end
            if (k < 3) begin @(posedge clk); #1; end
        end
        // dependent ADD in the last MUL cycle: operand comes from WB forward
        do_op(OP_ADD, 2, 2, 3, 32'd0);
        drain(to);
        n_checks++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL mul count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mul write: got cyc=%0d dr=%0d d=%h z=%0b c=%0b, required cyc=%0d dr=%0d d=%h z=%0b c=%0b",
                         o.cyc, o.dr, o.d, o.z, o.c, e.cyc, e.dr, e.d, e.z, e.c);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_checks++;
        if (rf[2] !== 32'h0007_0015 || rf[3] !== 32'h000E_002A) begin
            n_fail++; $display("FAIL mul regs: got R2=%h R3=%h, required 00070015 000e002a", rf[2], rf[3]);
        end
    endtask

    task automatic test_reset_mid_mul;
        bit to; int n;
        do_op(OP_LDI, 0, 0, 2, 32'hCAFE_0001);
        do_op(OP_LDI, 0, 0, 0, 32'h11);
        do_op(OP_LDI, 0, 0, 1, 32'h22);
        drain(to);
        n_checks++;
        if (to || obs_q.size() != 3) begin
            n_fail++; $display("FAIL rstmul setup: got %0d writes, required 3", obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
        issue(OP_MUL, 0, 1, 2, 32'd0, n);   // MUL cycle 1
        @(posedge clk); #1;                  // MUL cycle 2
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mcf = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmul ready: got %0b, required 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rf_write !== 1'b0) begin n_fail++; $display("FAIL rstmul write cyc%0d: got %0b, required 0", i, rf_write); end
            @(posedge clk); #1;
        end
        n_checks++;
        if (obs_q.size() != 0 || rf[2] !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL rstmul dest: got %0d writes R2=%h, required 0 cafe0001", obs_q.size(), rf[2]);
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        bit to; wr_t e, o;
        for (int i = 0; i < 24; i++)
            do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), $urandom);
        drain(to);
        n_checks++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b write: got cyc=%0d dr=%0d d=%h z=%0b c=%0b, required cyc=%0d dr=%0d d=%h z=%0b c=%0b",
                         o.cyc, o.dr, o.d, o.z, o.c, e.cyc, e.dr, e.d, e.z, e.c);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset;
        test_ldi_add;
        test_sub;
        test_carry;
        test_mul;
        test_reset_mid_mul;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
